dmi_req_bridge: RTL

DMI_REQ_BRIDGE -- requirements
Module: dmi_req_bridge

---
 rtl/dmi_req_bridge.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dmi_req_bridge.sv
// Host-to-DMI request bridge: buffers host requests in a FIFO and runs one DMI transaction at a
// time. Optional response timeout is compiled in with `define DMI_TIMEOUT_EN.
module dmi_req_bridge #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        host_req_valid_i,
  output logic                        host_req_ready_o,
  input  logic [1:0]                  host_req_op_i,
  input  logic [6:0]                  host_req_address_i,
  input  logic [31:0]                 host_req_data_i,
  output logic                        host_rsp_valid_o,
  input  logic                        host_rsp_ready_i,
  output logic [1:0]                  host_rsp_op_o,
  output logic [31:0]                 host_rsp_data_o,
  output logic                        dmi_req_valid_o,
  input  logic                        dmi_req_ready_i,
  output logic [1:0]                  dmi_req_op_o,
  output logic [6:0]                  dmi_req_address_o,
  output logic [31:0]                 dmi_req_data_o,
  input  logic                        dmi_rsp_valid_i,
  input  logic [1:0]                  dmi_rsp_op_i,
  input  logic [31:0]                 dmi_rsp_data_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = 41;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp, StRspHold} state_e;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES == 0) begin : g_cfg_check
    $error("dmi_req_bridge: unsupported FIFO_DEPTH or TIMEOUT_CYCLES");
  end

  state_e          r_state, w_state_next;
  logic [EntW-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_count;
  logic [1:0]      r_iss_op;
  logic [6:0]      r_iss_addr;
  logic [31:0]     r_iss_data;
  logic [1:0]      r_rsp_op;
  logic [31:0]     r_rsp_data;
  logic            w_push, w_pop, w_empty, w_full, w_local, w_rsp_take, w_dmi_accept;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CntW'(FIFO_DEPTH));
  assign w_push       = host_req_valid_i && host_req_ready_o;
  assign w_pop        = !w_empty &&
                        ((r_state == StIdle) || (r_state == StRspHold && host_rsp_ready_i));
  // nop and reserved ops are answered locally without touching the DMI
  assign w_local      = (r_iss_op == 2'b00) || (r_iss_op == 2'b11);
  assign w_dmi_accept = (r_state == StIssue) && !w_local && dmi_req_ready_i;
  assign w_rsp_take   = (r_state == StWaitRsp) && dmi_rsp_valid_i;

`ifdef DMI_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0] r_to_cnt;
  logic           w_timeout;

  assign w_timeout = (r_state == StWaitRsp) && !dmi_rsp_valid_i &&
                     (r_to_cnt == ToW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (w_dmi_accept) begin
      r_to_cnt <= '0;
    end else if (r_state == StWaitRsp) begin
      r_to_cnt <= r_to_cnt + ToW'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {host_req_op_i, host_req_address_i, host_req_data_i};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_iss_op   <= '0;
      r_iss_addr <= '0;
      r_iss_data <= '0;
    end else if (w_pop) begin
      {r_iss_op, r_iss_addr, r_iss_data} <= r_mem[r_rptr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_op   <= '0;
      r_rsp_data <= '0;
    end else if (r_state == StIssue && w_local) begin
      r_rsp_op   <= (r_iss_op == 2'b11) ? 2'b10 : 2'b00;
      r_rsp_data <= '0;
    end else if (w_rsp_take) begin
      r_rsp_op   <= dmi_rsp_op_i;
      r_rsp_data <= dmi_rsp_data_i;
`ifdef DMI_TIMEOUT_EN
    end else if (w_timeout) begin
      r_rsp_op   <= 2'b10;
      r_rsp_data <= '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (!w_empty) w_state_next = StIssue;
      StIssue: begin
        if (w_local)              w_state_next = StRspHold;
        else if (dmi_req_ready_i) w_state_next = StWaitRsp;
      end
      StWaitRsp: begin
        if (dmi_rsp_valid_i) w_state_next = StRspHold;
`ifdef DMI_TIMEOUT_EN
        else if (w_timeout)  w_state_next = StRspHold;
`endif
      end
      StRspHold: if (host_rsp_ready_i) w_state_next = w_empty ? StIdle : StIssue;
      default:   w_state_next = StIdle;
    endcase
  end

  always_comb begin
    host_req_ready_o  = reset && !w_full;
    dmi_req_valid_o   = (r_state == StIssue) && !w_local;
    host_rsp_valid_o  = (r_state == StRspHold);
    dmi_req_op_o      = r_iss_op;
    dmi_req_address_o = r_iss_addr;
    dmi_req_data_o    = r_iss_data;
    host_rsp_op_o     = r_rsp_op;
    host_rsp_data_o   = r_rsp_data;
    fifo_count_o      = r_count;
  end

endmodule
